spi_master: RTL

Single-slave-select-group SPI master (mode 0) that turns a request/response handshake into an SCK/SS/MOSI waveform and captures MISO into a response word. It sits directly upstream of the SPI peripheral models (e.g. the bit-reverse slave) and drives their `sck`, `ss`, `mosi`, consuming their `miso`. Bus-side adapters (APB/AXI-lite) connect to the request/response ports.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_clkgen.sv | 21 ++
 rtl/spi_master.sv | 136 +++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master slice: FSM state encoding, mode-0 idle levels, default sizes.
// Pure declarations, no logic; no latency or backpressure of its own.
// Imported by spi_master and spi_clkgen.
package spi_pkg;
  localparam int DEF_MAX_BITS = 16;
  localparam int DEF_SS_W     = 8;
  localparam int DEF_DIV_W    = 8;

  // Mode 0: SCK idles low, selects are active-low
  localparam logic SCK_IDLE = 1'b0;
  localparam logic SS_OFF   = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    DONE
  } state_t;
endpackage

// File: rtl/spi_clkgen.sv
// Half-period timer: one-cycle tick every H = div+1 clocks while enabled, reloads on tick or when disabled.
// Latency: first tick H clocks after en rises (counter preloaded with div while disabled).
// Backpressure: none; the FSM simply advances on tick.
module spi_clkgen import spi_pkg::*; #(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || !en || cnt == '0) cnt <= div;
    else                           cnt <= cnt - 1'b1;
  end

  assign tick = en && (cnt == '0);
endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: request word -> SCK/SS/MOSI waveform, MISO captured into a response word.
// Latency: rsp_valid at 1 + (2N+2)H cycles after accept; N = req_len+1, H = req_div+1.
// Backpressure: req_ready only in IDLE; holds DONE until rsp_ready. SPI_MASTER_LSB_FIRST_EN selects LSB-first.
module spi_master import spi_pkg::*; #(
  parameter int MAX_BITS = DEF_MAX_BITS,
  parameter int SS_W     = DEF_SS_W,
  parameter int DIV_W    = DEF_DIV_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [MAX_BITS-1:0]         req_data,
  input  logic [$clog2(MAX_BITS)-1:0] req_len,
  input  logic [SS_W-1:0]             req_ss,
  input  logic [DIV_W-1:0]            req_div,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [MAX_BITS-1:0]         rsp_data,
  output logic                        sck,
  output logic [SS_W-1:0]             ss,
  output logic                        mosi,
  input  logic                        miso
);
  localparam int LEN_W = $clog2(MAX_BITS);

  state_t              state;
  logic [MAX_BITS-1:0] tx_q, rx_q;
  logic [MAX_BITS-1:0] tx_init, tx_load, tx_next, rx_next;
  logic [LEN_W-1:0]    bit_cnt;
  logic [DIV_W-1:0]    div_q, div_sel;
  logic                first_bit, next_bit, tick, cg_en;

`ifdef SPI_MASTER_LSB_FIRST_EN
  logic [LEN_W-1:0] len_q;

  always_ff @(posedge clock) begin
    if (reset)                         len_q <= '0;
    else if (state == IDLE && req_valid) len_q <= req_len;
  end
`endif

  // tx_q holds only the bits not yet on the wire; the current bit lives in mosi
  always_comb begin
    tx_init = req_data;
`ifdef SPI_MASTER_LSB_FIRST_EN
    first_bit  = tx_init[0];
    tx_load    = tx_init >> 1;
    next_bit   = tx_q[0];
    tx_next    = tx_q >> 1;
    rx_next    = rx_q >> 1;
    rx_next[len_q] = miso;
`else
    tx_init    = req_data << (MAX_BITS - 1 - int'(req_len));
    first_bit  = tx_init[MAX_BITS-1];
    tx_load    = tx_init << 1;
    next_bit   = tx_q[MAX_BITS-1];
    tx_next    = tx_q << 1;
    rx_next    = {rx_q[MAX_BITS-2:0], miso};
`endif
  end

  // The timer must be primed with the incoming divider during the accept cycle
  assign div_sel = (state == IDLE) ? req_div : div_q;
  assign cg_en   = (state == SETUP) || (state == HIGH) || (state == LOW) || (state == HOLD);

  spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clock (clock),
    .reset (reset),
    .en    (cg_en),
    .div   (div_sel),
    .tick  (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      sck       <= SCK_IDLE;
      ss        <= {SS_W{SS_OFF}};
      mosi      <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      bit_cnt   <= '0;
      div_q     <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          state     <= SETUP;
          req_ready <= 1'b0;
          tx_q      <= tx_load;
          rx_q      <= '0;
          bit_cnt   <= req_len;
          div_q     <= req_div;
          ss        <= ~req_ss;
          mosi      <= first_bit;
          sck       <= SCK_IDLE;
        end
        SETUP: if (tick) begin
          state <= HIGH;
          sck   <= ~SCK_IDLE;
        end
        HIGH: if (tick) begin
          state <= LOW;
          sck   <= SCK_IDLE;
          rx_q  <= rx_next;
          tx_q  <= tx_next;
          mosi  <= next_bit;
        end
        LOW: if (tick) begin
          if (bit_cnt == '0) begin
            state <= HOLD;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
            state   <= HIGH;
            sck     <= ~SCK_IDLE;
          end
        end
        HOLD: if (tick) begin
          state     <= DONE;
          ss        <= {SS_W{SS_OFF}};
          rsp_valid <= 1'b1;
          rsp_data  <= rx_q;
        end
        DONE: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
